frame_stream_source: RTL and testbench
======================================

// Module: frame_stream_source
// PURPOSE
//  Reads a stored RGB frame from a 1-cycle-latency frame-buffer read port and streams it in raster
//  order (x fastest, then y) as a pixel_valid_if master. Feeds the line-buffered filter blocks'
//  pixel_valid_if slave input; start_i launches one frame, done_o pulses when it has been sent.
//  Optional blanking between lines via LINE_GAP; pause_i lets the test harness throttle issue.
// PARAMETERS
//  IMAGE_LEN     1080  pixels per line
//  IMAGE_HEIGHT  720   lines per frame
//  LINE_GAP      0     idle (valid=0) cycles inserted after each line except the last
//  ADDR_F        $clog2(IMAGE_LEN*IMAGE_HEIGHT)  frame-buffer address width (localparam)
// PORTS
//  clk               in   1       clock
//  rst_n             in   1       reset, asynchronous assert, active-low
//  start_i           in   1       start one frame; sampled only in IDLE
//  pause_i           in   1       1 = do not issue a read this cycle
//  mem_en_o          out  1       frame-buffer read enable
//  mem_addr_o        out  ADDR_F  read address, = y*IMAGE_LEN + x
//  mem_data_i        in   24      read data {red,green,blue}, valid 1 cycle after mem_en_o
//  pixel_valid_if_o  master 24+1  .pixel (red/green/blue, 8b each), .valid
//  busy_o            out  1       1 in any state other than IDLE
//  done_o            out  1       one-cycle pulse after last pixel
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; x,y,gap count,addr=0; mem_en_o=0, mem_addr_o=0,
//   valid=0, pixel=0, busy_o=0, done_o=0. Reset mid-frame aborts: no further valid, no done_o.
//  FSM states: IDLE, STREAM, GAP, FLUSH, DONE.
//   IDLE:   start_i=1 -> STREAM, x=y=0. start_i in any other state is ignored (not queued).
//   STREAM: if pause_i=0: mem_en_o=1, mem_addr_o=current address, then advance.
//           x<IMAGE_LEN-1: x++ ; x==IMAGE_LEN-1: x=0, and
//             y==IMAGE_HEIGHT-1 -> FLUSH; else y++, -> GAP if LINE_GAP>0 else stay STREAM.
//           pause_i=1: mem_en_o=0, x/y/addr held, state held.
//   GAP:    mem_en_o=0; counts LINE_GAP cycles (pause_i ignored) -> STREAM.
//   FLUSH:  mem_en_o=0; one cycle to return last in-flight read -> DONE.
//   DONE:   done_o=1 for exactly this cycle -> IDLE. start_i here is ignored.
//  mem_en_o/mem_addr_o are combinational from registered state/x/y/addr (no multiplier: address
//   is a running counter, reset to 0 on start, +1 per issued read).
//  Output stage: valid_q <= mem_en_o (registered); pixel <= mem_data_i when valid_q (sampled in
//   the cycle after issue); pixel held while valid=0. Exactly one valid per issued read, in order.
//  Latency: start_i high at cycle 0 -> first mem_en_o at cycle 1 -> first valid at cycle 2.
//   With no pause and LINE_GAP=0: valids contiguous cycles 2..N+1 (N=IMAGE_LEN*IMAGE_HEIGHT),
//   done_o at cycle N+2. Each LINE_GAP cycle and each paused STREAM cycle adds one cycle.
//  pause_i has no effect on an already-issued read; its data is still presented next cycle.
//  No backpressure: downstream must accept every valid cycle.
//  x range 0..IMAGE_LEN-1, y range 0..IMAGE_HEIGHT-1; address never exceeds N-1.
// TESTING
//  4x3, LINE_GAP=0, start at c0 -> mem_addr 0..11 c1..c12, valid c2..c13 with mem word k, done c14.
//  4x3, LINE_GAP=2 -> three bursts of 4 valids separated by exactly 2 idle cycles; done 1 cycle
//   after last valid in FLUSH+1; total 12 valids.
//  4x3, pause_i=1 for 3 cycles after addr 5 issued -> addr 6 issued 3 cycles later, pixel 5 still
//   emitted next cycle, no duplicate or dropped pixel, done delayed by 3.
//  start_i pulsed again mid-frame and during DONE -> ignored: exactly 12 valids, one done_o, busy_o
//   low after DONE; new start in IDLE launches fresh frame from addr 0.
//  rst_n low at addr 7 (async, mid-cycle) -> valid, mem_en_o, busy_o drop immediately, no done_o;
//   subsequent start streams full frame from addr 0.
//  1080x720 defaults, random pause_i 20% -> 777600 valids, raster order matches memory image,
//   done_o once.

Source files
------------

// File: rtl/frame_stream_source.sv
// frame_stream_source
//   Streams a stored RGB frame out of a frame buffer with a 1-cycle read
//   latency, in raster order (x fastest, then y). One frame is sent per
//   start_i pulse accepted in IDLE; done_o pulses once the last pixel has
//   been presented. Optional idle cycles (LINE_GAP) separate lines, and
//   pause_i holds back read issue for a cycle.
//
// Ports
//   clk         clock
//   rst_n       asynchronous, active-low reset
//   start_i     launch one frame (only looked at in IDLE)
//   pause_i     1 = issue no read this cycle (STREAM only)
//   mem_en_o    frame-buffer read enable
//   mem_addr_o  frame-buffer read address, y*IMAGE_LEN + x
//   mem_data_i  read data {red,green,blue}, valid the cycle after mem_en_o
//   pixel_o     output pixel {red,green,blue}, held while valid_o is low
//   valid_o     output pixel valid (pixel_valid_if .valid)
//   busy_o      1 whenever a frame is in progress
//   done_o      one-cycle pulse after the last pixel
module frame_stream_source #(
  parameter int IMAGE_LEN    = 1080,
  parameter int IMAGE_HEIGHT = 720,
  parameter int LINE_GAP     = 0,
  localparam int ADDR_F      = $clog2(IMAGE_LEN * IMAGE_HEIGHT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              pause_i,
  output logic              mem_en_o,
  output logic [ADDR_F-1:0] mem_addr_o,
  input  logic [23:0]       mem_data_i,
  output logic [23:0]       pixel_o,
  output logic              valid_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int X_W   = (IMAGE_LEN > 1)    ? $clog2(IMAGE_LEN)    : 1;
  localparam int Y_W   = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int GAP_W = (LINE_GAP > 1)     ? $clog2(LINE_GAP)     : 1;

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    GAP,
    FLUSH,
    DONE
  } state_t;

  state_t              state_reg, state_next;
  logic [X_W-1:0]      x_reg, x_next;
  logic [Y_W-1:0]      y_reg, y_next;
  logic [GAP_W-1:0]    gap_reg, gap_next;
  logic [ADDR_F-1:0]   addr_reg, addr_next;
  logic                valid_reg;
  logic [23:0]         pixel_hold_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      gap_reg   <= '0;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      gap_reg   <= gap_next;
      addr_reg  <= addr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    gap_next   = gap_reg;
    addr_next  = addr_reg;
    mem_en_o   = 1'b0;
    done_o     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          state_next = STREAM;
          x_next     = '0;
          y_next     = '0;
          gap_next   = '0;
          addr_next  = '0;
        end
      end
      STREAM: begin
        if (!pause_i) begin
          mem_en_o = 1'b1;
          if (x_reg != X_W'(IMAGE_LEN - 1)) begin
            x_next    = x_reg + X_W'(1);
            addr_next = addr_reg + ADDR_F'(1);
          end else begin
            x_next = '0;
            if (y_reg == Y_W'(IMAGE_HEIGHT - 1)) begin
              // Last read of the frame: park the address at 0 so it never
              // runs past the end of the buffer.
              y_next     = '0;
              addr_next  = '0;
              state_next = FLUSH;
            end else begin
              y_next    = y_reg + Y_W'(1);
              addr_next = addr_reg + ADDR_F'(1);
              if (LINE_GAP > 0) begin
                gap_next   = '0;
                state_next = GAP;
              end
            end
          end
        end
      end
      GAP: begin
        if (gap_reg == GAP_W'(LINE_GAP - 1)) begin
          gap_next   = '0;
          state_next = STREAM;
        end else begin
          gap_next = gap_reg + GAP_W'(1);
        end
      end
      FLUSH: state_next = DONE;   // last read's data is presented this cycle
      DONE: begin
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_addr_o = addr_reg;
  assign busy_o     = (state_reg != IDLE);

  // Read data arrives the cycle after issue, alongside valid_reg, so it is
  // passed straight through then and captured for holding afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg      <= 1'b0;
      pixel_hold_reg <= '0;
    end else begin
      valid_reg <= mem_en_o;
      if (valid_reg) begin
        pixel_hold_reg <= mem_data_i;
      end
    end
  end

  assign valid_o = valid_reg;
  assign pixel_o = valid_reg ? mem_data_i : pixel_hold_reg;

endmodule

// File: tb/tb_frame_stream_source.sv
module tb_frame_stream_source;

  localparam int LEN = 4;
  localparam int HGT = 3;
  localparam int N   = LEN * HGT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic pause = 1'b0;

  logic        en_a, val_a, busy_a, done_a;
  logic [3:0]  addr_a;
  logic [23:0] pix_a;
  logic [23:0] rd_a = '0;
  logic        en_b, val_b, busy_b, done_b;
  logic [3:0]  addr_b;
  logic [23:0] pix_b;
  logic [23:0] rd_b = '0;

  logic [23:0] img [N];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // model state, per instance (0: LINE_GAP=0, 1: LINE_GAP=2)
  bit          frame_on [2];
  int          issued   [2];
  int          gap_left [2];
  int          since    [2];
  bit          vld_pend [2];
  int          pend_addr[2];
  logic [23:0] pix_hold [2];
  // observed per-frame statistics
  int vcnt [2];
  int dcnt [2];
  int dcyc [2];
  int fvcyc[2];

  always #5 clk = ~clk;

  frame_stream_source #(.IMAGE_LEN(LEN), .IMAGE_HEIGHT(HGT), .LINE_GAP(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start), .pause_i(pause),
    .mem_en_o(en_a), .mem_addr_o(addr_a), .mem_data_i(rd_a),
    .pixel_o(pix_a), .valid_o(val_a), .busy_o(busy_a), .done_o(done_a)
  );

  frame_stream_source #(.IMAGE_LEN(LEN), .IMAGE_HEIGHT(HGT), .LINE_GAP(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start), .pause_i(pause),
    .mem_en_o(en_b), .mem_addr_o(addr_b), .mem_data_i(rd_b),
    .pixel_o(pix_b), .valid_o(val_b), .busy_o(busy_b), .done_o(done_b)
  );

  // frame buffers with one cycle of read latency
  always @(posedge clk) if (en_a) rd_a <= img[addr_a];
  always @(posedge clk) if (en_b) rd_b <= img[addr_b];

  function automatic int gap_of(input int i);
    return (i == 0) ? 0 : 2;
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[inst%0d] cycle %0d: got 0x%0h, expected 0x%0h", name, i, cyc, act, exp);
    end
  endtask

  task automatic model_reset(input int i);
    frame_on[i] = 0; issued[i] = 0; gap_left[i] = 0; since[i] = 0;
    vld_pend[i] = 0; pend_addr[i] = 0; pix_hold[i] = '0;
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 2; i++) begin
      vcnt[i] = 0; dcnt[i] = 0; dcyc[i] = -1; fvcyc[i] = -1;
    end
  endtask

  // Expected outputs follow from: reads issue in order 0..N-1 while a frame
  // is on and nothing holds them back, each read yields one valid next cycle,
  // and done comes two cycles after the final read.
  task automatic check_inst(input int i, input logic en, input logic [3:0] addr, input logic v,
                            input logic [23:0] pix, input logic bz, input logic dn);
    logic        e_en, e_v, e_bz, e_dn;
    logic [23:0] e_pix;
    e_en = 0; e_v = 0; e_bz = 0; e_dn = 0; e_pix = '0;
    if (rst_n) begin
      e_en  = frame_on[i] && issued[i] < N && gap_left[i] == 0 && !pause;
      e_v   = vld_pend[i];
      e_pix = vld_pend[i] ? img[pend_addr[i]] : pix_hold[i];
      e_bz  = frame_on[i];
      e_dn  = frame_on[i] && issued[i] == N && since[i] == 2;
    end
    chk("mem_en", i, 32'(en), 32'(e_en));
    if (e_en || !rst_n) chk("mem_addr", i, 32'(addr), rst_n ? 32'(issued[i]) : 32'd0);
    chk("valid", i, 32'(v), 32'(e_v));
    chk("pixel", i, 32'(pix), 32'(e_pix));
    chk("busy", i, 32'(bz), 32'(e_bz));
    chk("done", i, 32'(dn), 32'(e_dn));
    if (v === 1'b1) begin
      vcnt[i]++;
      if (fvcyc[i] < 0) fvcyc[i] = cyc;
    end
    if (dn === 1'b1) begin
      dcnt[i]++;
      dcyc[i] = cyc;
    end
    // advance the model across the coming clock edge
    if (!rst_n) begin
      model_reset(i);
    end else begin
      vld_pend[i] = e_en;
      if (e_en) pend_addr[i] = issued[i];
      if (e_v) pix_hold[i] = e_pix;
      if (!frame_on[i]) begin
        if (start) begin
          frame_on[i] = 1; issued[i] = 0; gap_left[i] = 0; since[i] = 0;
        end
      end else if (e_dn) begin
        frame_on[i] = 0;
      end else if (issued[i] == N) begin
        since[i]++;
      end else if (gap_left[i] > 0) begin
        gap_left[i]--;
      end else if (e_en) begin
        issued[i]++;
        if (issued[i] == N) since[i] = 1;
        else if (issued[i] % LEN == 0) gap_left[i] = gap_of(i);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_inst(0, en_a, addr_a, val_a, pix_a, busy_a, done_a);
    check_inst(1, en_b, addr_b, val_b, pix_b, busy_b, done_b);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic start_frame(output int s);
    clear_stats();
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy_a || busy_b) && k < 200) begin
      tick();
      k++;
    end
    n_checks++;
    if (k >= 200) begin
      n_fail++;
      $display("FAIL idle_timeout cycle %0d: got busy after %0d cycles, expected idle", cyc, k);
    end
    tick();
    tick();
  endtask

  task automatic frame_report(input string tag, input int s, input int lat_a, input int lat_b);
    chk("done_latency", 0, 32'(dcyc[0] - s), 32'(lat_a));
    chk("done_latency", 1, 32'(dcyc[1] - s), 32'(lat_b));
    chk("first_valid_latency", 0, 32'(fvcyc[0] - s), 32'd2);
    chk("first_valid_latency", 1, 32'(fvcyc[1] - s), 32'd2);
    chk("valid_count", 0, 32'(vcnt[0]), 32'(N));
    chk("valid_count", 1, 32'(vcnt[1]), 32'(N));
    chk("done_count", 0, 32'(dcnt[0]), 32'd1);
    chk("done_count", 1, 32'(dcnt[1]), 32'd1);
    $display("frame %s: gap0 valids=%0d done@+%0d | gap2 valids=%0d done@+%0d",
             tag, vcnt[0], dcyc[0] - s, vcnt[1], dcyc[1] - s);
  endtask

  initial begin
    int s;
    for (int k = 0; k < N; k++) begin
      img[k] = {8'(k * 37 + 5), 8'(8'hA0 ^ k), 8'(200 - k * 9)};
    end
    model_reset(0);
    model_reset(1);
    clear_stats();

    // reset state
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // plain frame
    start_frame(s);
    wait_idle();
    frame_report("plain", s, 14, 18);

    // pause for 3 cycles right after address 5 is issued by the gap-0 block
    start_frame(s);
    run_until(s + 7);
    pause = 1'b1;
    repeat (3) tick();
    pause = 1'b0;
    wait_idle();
    frame_report("paused", s, 17, 21);

    // start pulses mid-frame and while the gap-0 block is in DONE
    start_frame(s);
    run_until(s + 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    run_until(s + 14);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle();
    frame_report("restart_ignored", s, 14, 18);

    // asynchronous reset mid-cycle just after address 7 is issued
    start_frame(s);
    run_until(s + 8);
    #1 rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("abort_done_count", 0, 32'(dcnt[0]), 32'd0);
    chk("abort_done_count", 1, 32'(dcnt[1]), 32'd0);
    chk("abort_valid_count", 0, 32'(vcnt[0]), 32'd6);
    chk("abort_valid_count", 1, 32'(vcnt[1]), 32'd4);
    $display("frame aborted: gap0 valids=%0d | gap2 valids=%0d", vcnt[0], vcnt[1]);

    // fresh frame after the abort
    start_frame(s);
    wait_idle();
    frame_report("after_reset", s, 14, 18);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
